// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU and response channels of the execute-stage issue controller.
// The controller takes the master modport since it initiates every ALU evaluation.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_aluop;
    logic [5:0]       req_funct;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic [3:0]       alu_control;
    logic [WIDTH-1:0] alu_data1;
    logic [WIDTH-1:0] alu_data2;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;

    modport master (
        input  req_valid, req_aluop, req_funct, req_a, req_b,
        input  alu_result, alu_zero, rsp_ready,
        output req_ready, alu_control, alu_data1, alu_data2,
        output rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        output req_valid, req_aluop, req_funct, req_a, req_b,
        output alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_control, alu_data1, alu_data2,
        input  rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer: decodes ALUOp/funct, walks control then operands onto an
// edge-evaluated ALU, and returns the captured result over a response handshake.
module alu_issue_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_ctrl_if.master   bus,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CTRL = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       control_q;
    logic [WIDTH-1:0] data1_q;
    logic [WIDTH-1:0] data2_q;
    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             err_q;

    logic [3:0]       dec_code;
    logic             dec_legal;
    logic             ready;
    logic             accept;
    logic             pop;

    always_comb begin
        dec_code  = 4'b0000;
        dec_legal = 1'b1;
        case (bus.req_aluop)
            2'b00: dec_code = 4'b0010;
            2'b01: dec_code = 4'b0110;
            2'b10: begin
                case (bus.req_funct)
                    6'b100000: dec_code = 4'b0010;
                    6'b100010: dec_code = 4'b0110;
                    6'b100100: dec_code = 4'b0000;
                    6'b100101: dec_code = 4'b0001;
                    6'b100111: dec_code = 4'b1100;
                    6'b101010: dec_code = 4'b0111;
                    default:   dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                ready = rst_n;
                busy  = 1'b0;
                if (bus.req_valid && rst_n) begin
                    state_next = dec_legal ? CTRL : RESP;
                end
            end
            CTRL: state_next = DATA;
            DATA: state_next = RESP;
            RESP: begin
                if (valid_q && bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = bus.req_valid && ready;
    assign pop    = valid_q && bus.rsp_ready;

    // data1 is driven to ~a on accept so the CTRL-cycle move to a is always a real change,
    // which makes the ALU re-evaluate under the new control even for repeated operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            control_q <= 4'b0000;
            data1_q   <= '0;
            data2_q   <= '0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (dec_legal) begin
                            a_q       <= bus.req_a;
                            b_q       <= bus.req_b;
                            control_q <= dec_code;
                            data1_q   <= ~bus.req_a;
                        end else begin
                            result_q <= '0;
                            zero_q   <= 1'b0;
                            err_q    <= 1'b1;
                            valid_q  <= 1'b1;
                        end
                    end
                end
                CTRL: begin
                    data1_q <= a_q;
                    data2_q <= b_q;
                end
                DATA: begin
                    result_q <= bus.alu_result;
                    zero_q   <= bus.alu_zero;
                    err_q    <= 1'b0;
                    valid_q  <= 1'b1;
                end
                RESP: begin
                    if (pop) begin
                        valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready   = ready;
    assign bus.alu_control = control_q;
    assign bus.alu_data1   = data1_q;
    assign bus.alu_data2   = data2_q;
    assign bus.rsp_valid   = valid_q;
    assign bus.rsp_result  = result_q;
    assign bus.rsp_zero    = zero_q;
    assign bus.rsp_err     = err_q;

    valid_tracks_resp: assert property (@(posedge clk) disable iff (!rst_n)
        valid_q == (state == RESP));

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Execute-stage sequencer that acts as the initiator side of the ALU interface. It accepts one operation per request handshake and decodes ALUOp/funct into the 4-bit ALU control code. It sequences control and operands onto the ALU ports so the combinational ALU is guaranteed to re-evaluate, then captures result and zero flag and returns them on a response handshake. It sits between ID/EX decode and the 32-bit ALU.

## Interface
- WIDTH, 32, operand/result width (ALU is 32-bit; other values unsupported)
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE and when rst_n=1
- req_aluop  in  2  00 load/store add, 01 branch subtract, 10 R-type (use funct), 11 illegal
- req_funct  in  6  R-type funct field
- req_a, req_b  in  WIDTH  operands
- alu_control  out  4  to ALU control
- alu_data1, alu_data2  out  WIDTH  to ALU operands
- alu_result  in  WIDTH  from ALU
- alu_zero  in  1  from ALU zero flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts
- rsp_result  out  WIDTH  captured result
- rsp_zero  out  1  captured zero flag
- rsp_err  out  1  illegal ALUOp/funct
- busy  out  1  state != IDLE

## Operation
- Decode: aluop 00 -> 0010; aluop 01 -> 0110; aluop 11 -> illegal.
- aluop 10 decodes by funct:
  - 100000 -> 0010 (add); 100010 -> 0110 (sub); 100100 -> 0000 (and)
  - 100101 -> 0001 (or); 100111 -> 1100 (nor); 101010 -> 0111 (slt)
  - any other funct -> illegal.
- The ALU evaluates only on operand change, so control must be stable before operands move, and operands must change for every legal request.
- FSM states: IDLE, CTRL, DATA, RESP.
- IDLE, on req_valid && req_ready with a legal decode:
  - latch req_a and req_b;
  - set alu_control to the decoded code;
  - set alu_data1 to ~req_a; alu_data2 is unchanged;
  - go to CTRL.
- IDLE, on handshake with an illegal decode:
  - ALU ports are unchanged;
  - rsp_result=0, rsp_zero=0, rsp_err=1, rsp_valid=1;
  - go to RESP.
- CTRL: alu_data1 <= latched a; alu_data2 <= latched b; go to DATA. data1 always changes here, which forces ALU re-evaluation under the new control.
- DATA: capture alu_result into rsp_result and alu_zero into rsp_zero; rsp_err=0; rsp_valid=1; go to RESP.
- RESP: hold all rsp_* stable. On rsp_valid && rsp_ready: rsp_valid=0, go to IDLE. rsp_err and rsp_result keep their values until the next capture.
- One operation in flight. req_valid is ignored outside IDLE. A response pop and a new accept never occur on the same edge.
- rsp_zero is the ALU zero flag (data1 == data2) regardless of operation. It is not reinterpreted.

## Timing
- Reset (rst_n=0 at an edge):
  - state IDLE;
  - alu_control=0000, alu_data1=0, alu_data2=0;
  - rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, busy=0;
  - req_ready=0 while rst_n=0, and 1 from the first cycle after release.
- Legal request accepted at edge E0:
  - alu_control and ~a visible after E0;
  - a and b visible after E1;
  - capture at E2; rsp_valid high after E2.
  - Minimum request-to-response is 2 cycles; back-to-back throughput is 1 operation per 4 cycles when rsp_ready=1.
- Illegal request accepted at E0: rsp_valid high after E0.
- Backpressure: rsp_ready low holds RESP indefinitely. Outputs are stable and req_ready=0.
- Reset mid-operation (any state): aborts immediately, with no response and the reset values above.
- Identical consecutive operands are handled by the CTRL-cycle inversion. No special case is needed.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with req_valid=1 -> all outputs at reset values and req_ready=0. Release -> req_ready=1 on the next cycle.
- R-type add: funct 100000, a=5, b=7 -> alu_control=0010 after E0, rsp_result=12, rsp_zero=0, rsp_err=0, rsp_valid after E2.
- Branch: aluop 01, a=b=0x00001234 -> alu_control=0110, rsp_result=0, rsp_zero=1.
- Same operands, new op: AND a=0x0000F0F0, b=0x00000FF0 -> 0x000000F0. Then OR with the same a and b -> 0x0000FFF0, which proves re-evaluation.
- slt a=3, b=9 -> rsp_result=1. Then aluop 10 with funct 000000 -> rsp_err=1, rsp_result=0, rsp_valid after E0, ALU ports unchanged.
- Backpressure and abort:
  - rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, and a concurrent req_valid is not accepted.
  - Then rst_n=0 while in CTRL on a new request -> rsp_valid never asserts and state returns to IDLE.
